// File: rtl/prescaled_counter_if.sv
// prescaled_counter_if
//   Groups the control inputs and status outputs of prescaled_counter.
//   master : the controller side (hatch FSM or bench) that drives the controls.
//   slave  : the counter itself.
//
//   Signal protocol: there is no valid/ready handshake. Every control signal
//   (st, clr, load, load_val, limit, dir, wrap_en) is a level that the counter
//   samples on each rising clk edge. Every status signal (cnt_num, tick, done,
//   expired) is registered and changes only on a rising clk edge.
interface prescaled_counter_if #(
    parameter int CNT_W = 5
);
    logic             st;
    logic             clr;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] limit;
    logic             dir;
    logic             wrap_en;
    logic [CNT_W-1:0] cnt_num;
    logic             tick;
    logic             done;
    logic             expired;

    modport master (
        output st, clr, load, load_val, limit, dir, wrap_en,
        input  cnt_num, tick, done, expired
    );

    modport slave (
        input  st, clr, load, load_val, limit, dir, wrap_en,
        output cnt_num, tick, done, expired
    );
endinterface

// File: rtl/prescaled_counter.sv
// prescaled_counter
//   A prescaler divides clk by DIV and emits a one-cycle tick; a CNT_W-bit
//   counter steps on each tick, up or down, wrapping or saturating at its
//   terminal value. done pulses when the terminal value is reached and
//   expired remembers it until reset, clr or load.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-low reset
//     bus  - prescaled_counter_if.slave: st, clr, load, load_val, limit, dir,
//            wrap_en in; cnt_num, tick, done, expired out (all registered)
//   Parameters:
//     DIV   - prescaler period in clk cycles (must be >= 2)
//     CNT_W - counter width
module prescaled_counter #(
    parameter int DIV   = 1000,
    parameter int CNT_W = 5
) (
    input logic                clk,
    input logic                rst,
    prescaled_counter_if.slave bus
);
    localparam int            PW     = $clog2(DIV);
    localparam logic [PW-1:0] Q_LAST = PW'(DIV - 1);

    logic [PW-1:0]    q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             done_q;
    logic             expired_q;

    logic             period_end;
    logic [CNT_W-1:0] load_clamped;
    logic [CNT_W-1:0] cnt_step;
    logic             step_hits_term;

    // The count step happens on the same edge that registers tick.
    assign period_end   = bus.st && (q == Q_LAST);
    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

    // Next count for a tick edge. step_hits_term is raised only when a real
    // step lands on the terminal value, so a saturated count that merely
    // holds there never re-pulses done. A count above limit (limit lowered
    // at runtime) counts as terminal in up mode.
    always_comb begin
        cnt_step       = cnt_q;
        step_hits_term = 1'b0;
        if (!bus.dir) begin
            if (cnt_q < bus.limit) begin
                cnt_step       = cnt_q + CNT_W'(1);
                step_hits_term = (cnt_step == bus.limit);
            end else if (bus.wrap_en) begin
                cnt_step = '0;
            end
        end else begin
            if (cnt_q != '0) begin
                cnt_step       = cnt_q - CNT_W'(1);
                step_hits_term = (cnt_step == '0);
            end else if (bus.wrap_en) begin
                cnt_step = bus.limit;
            end
        end
    end

    // clr yields exactly the reset state, so both share one branch.
    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            q         <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            // The prescaler keeps running through a load.
            if (bus.st) begin
                if (q == Q_LAST) begin
                    q      <= '0;
                    tick_q <= 1'b1;
                end else begin
                    q <= q + PW'(1);
                end
            end
            // load wins over a coincident count step and clears the flags.
            if (bus.load) begin
                cnt_q     <= load_clamped;
                expired_q <= 1'b0;
            end else if (period_end) begin
                cnt_q <= cnt_step;
                if (step_hits_term) begin
                    done_q    <= 1'b1;
                    expired_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cnt_num = cnt_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_prescaled_counter.sv
module tb_prescaled_counter;
    localparam int DIV   = 4;
    localparam int CNT_W = 5;
    localparam int W     = CNT_W + 3;

    typedef struct {
        string            name;
        logic             rst;
        logic             st;
        logic             clr;
        logic             load;
        logic [CNT_W-1:0] load_val;
        logic [CNT_W-1:0] limit;
        logic             dir;
        logic             wrap_en;
        int               ncyc;
        logic [CNT_W-1:0] cnt;
        logic             tick;
        logic             done;
        logic             expired;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prescaled_counter_if #(.CNT_W(CNT_W)) bus ();

    prescaled_counter #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    task automatic push_exp(input logic [CNT_W-1:0] cnt, input logic tick,
                            input logic done, input logic expired);
        exp_q.push_back({cnt, tick, done, expired});
    endtask

    task automatic check(input string name);
        logic [W-1:0] exp;
        logic [W-1:0] act;
        act = {bus.cnt_num, bus.tick, bus.done, bus.expired};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued, got cnt=%0d tick=%0b done=%0b expired=%0b",
                     name, act[W-1:3], act[2], act[1], act[0]);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s: got cnt=%0d tick=%0b done=%0b expired=%0b, want cnt=%0d tick=%0b done=%0b expired=%0b",
                         name, act[W-1:3], act[2], act[1], act[0],
                         exp[W-1:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic st, input logic clr, input logic load,
                         input logic [CNT_W-1:0] lv, input logic [CNT_W-1:0] lim,
                         input logic dir, input logic wrap);
        rst          = r;
        bus.st       = st;
        bus.clr      = clr;
        bus.load     = load;
        bus.load_val = lv;
        bus.limit    = lim;
        bus.dir      = dir;
        bus.wrap_en  = wrap;
    endtask

    // Advance n rising edges, then settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic r, input logic st, input logic clr,
                       input logic load, input int lv, input int lim, input logic dir,
                       input logic wrap, input int ncyc, input int cnt, input logic tick,
                       input logic done, input logic expired);
        vec_t v;
        v.name = name; v.rst = r; v.st = st; v.clr = clr; v.load = load;
        v.load_val = CNT_W'(lv); v.limit = CNT_W'(lim); v.dir = dir; v.wrap_en = wrap;
        v.ncyc = ncyc; v.cnt = CNT_W'(cnt); v.tick = tick; v.done = done; v.expired = expired;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].clr, vecs[i].load,
                  vecs[i].load_val, vecs[i].limit, vecs[i].dir, vecs[i].wrap_en);
            push_exp(vecs[i].cnt, vecs[i].tick, vecs[i].done, vecs[i].expired);
            step(vecs[i].ncyc);
            check(vecs[i].name);
        end
        vecs.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        logic [CNT_W-1:0] lv;
        logic [CNT_W-1:0] lim;

        //  name           rst st clr ld lv lim dir wr ncyc cnt tk dn ex
        // Reset and basic count: ticks at edges 4, 8, 12 after release.
        add("reset_hold",    0, 0, 0, 0, 0, 10, 0, 1, 2,  0, 0, 0, 0);
        add("basic_e3",      1, 1, 0, 0, 0, 10, 0, 1, 3,  0, 0, 0, 0);
        add("basic_e4",      1, 1, 0, 0, 0, 10, 0, 1, 1,  1, 1, 0, 0);
        add("basic_e7",      1, 1, 0, 0, 0, 10, 0, 1, 3,  1, 0, 0, 0);
        add("basic_e8",      1, 1, 0, 0, 0, 10, 0, 1, 1,  2, 1, 0, 0);
        add("basic_e12",     1, 1, 0, 0, 0, 10, 0, 1, 4,  3, 1, 0, 0);
        // Up count, wrap at limit 3.
        add("clr_a",         1, 1, 1, 0, 0,  3, 0, 1, 1,  0, 0, 0, 0);
        add("wrap_t1",       1, 1, 0, 0, 0,  3, 0, 1, 4,  1, 1, 0, 0);
        add("wrap_t2",       1, 1, 0, 0, 0,  3, 0, 1, 4,  2, 1, 0, 0);
        add("wrap_t3_done",  1, 1, 0, 0, 0,  3, 0, 1, 4,  3, 1, 1, 1);
        add("wrap_done_end", 1, 1, 0, 0, 0,  3, 0, 1, 1,  3, 0, 0, 1);
        add("wrap_t4_zero",  1, 1, 0, 0, 0,  3, 0, 1, 3,  0, 1, 0, 1);
        add("wrap_t5",       1, 1, 0, 0, 0,  3, 0, 1, 4,  1, 1, 0, 1);
        // Up count, saturate at limit 3.
        add("clr_b",         1, 1, 1, 0, 0,  3, 0, 0, 1,  0, 0, 0, 0);
        add("sat_t3_done",   1, 1, 0, 0, 0,  3, 0, 0, 12, 3, 1, 1, 1);
        add("sat_done_end",  1, 1, 0, 0, 0,  3, 0, 0, 1,  3, 0, 0, 1);
        add("sat_t4_hold",   1, 1, 0, 0, 0,  3, 0, 0, 3,  3, 1, 0, 1);
        add("sat_t5_hold",   1, 1, 0, 0, 0,  3, 0, 0, 4,  3, 1, 0, 1);
        // Down count with wrap to limit 5.
        add("down_load",     1, 0, 0, 1, 2,  5, 1, 1, 1,  2, 0, 0, 0);
        add("down_t1",       1, 1, 0, 0, 2,  5, 1, 1, 4,  1, 1, 0, 0);
        add("down_t2_done",  1, 1, 0, 0, 2,  5, 1, 1, 4,  0, 1, 1, 1);
        add("down_t3_wrap",  1, 1, 0, 0, 2,  5, 1, 1, 4,  5, 1, 0, 1);
        add("down_t4",       1, 1, 0, 0, 2,  5, 1, 1, 4,  4, 1, 0, 1);
        add("pause_q2",      1, 1, 0, 0, 0, 10, 0, 1, 2,  4, 0, 0, 1);
        run_vecs();

        // Pause: q is 2; freeze for 7 edges, then two more edges give the tick.
        drive(1, 0, 0, 0, 0, 10, 0, 1);
        for (int i = 0; i < 7; i++) begin
            push_exp(4, 0, 0, 1);
            step(1);
            check($sformatf("pause_hold%0d", i));
        end
        drive(1, 1, 0, 0, 0, 10, 0, 1);
        push_exp(4, 0, 0, 1);
        step(1);
        check("restart_e1");
        push_exp(5, 1, 0, 1);
        step(1);
        check("restart_e2_tick");

        //  name           rst st clr ld lv lim dir wr ncyc cnt tk dn ex
        // Load with clamp on a tick edge, then clr together with load.
        add("pre_load_q3",   1, 1, 0, 0, 0, 10, 0, 1, 3,  5, 0, 0, 1);
        add("load_clamp",    1, 1, 0, 1, 20, 10, 0, 1, 1, 10, 1, 0, 0);
        add("clr_and_load",  1, 1, 1, 1, 20, 10, 0, 1, 1,  0, 0, 0, 0);
        // Reset mid-period at cnt 7, q 3.
        add("load7",         1, 1, 0, 1, 7, 10, 0, 1, 1,  7, 0, 0, 0);
        add("cnt7_q3",       1, 1, 0, 0, 7, 10, 0, 1, 2,  7, 0, 0, 0);
        add("mid_reset",     0, 1, 0, 0, 7, 10, 0, 1, 1,  0, 0, 0, 0);
        add("post_rst_e3",   1, 1, 0, 0, 7, 10, 0, 1, 3,  0, 0, 0, 0);
        add("post_rst_e4",   1, 1, 0, 0, 7, 10, 0, 1, 1,  1, 1, 0, 0);
        add("ld_eq_limit",   1, 0, 0, 1, 31, 31, 0, 1, 1, 31, 0, 0, 0);
        run_vecs();

        // Random loads with the prescaler stopped: count is min(load_val, limit).
        for (int i = 0; i < 10; i++) begin
            lv  = CNT_W'($urandom_range(0, 31));
            lim = CNT_W'($urandom_range(0, 31));
            drive(1, 0, 0, 1, lv, lim, 0, 1);
            push_exp((lv > lim) ? lim : lv, 0, 0, 0);
            step(1);
            check($sformatf("rand_load%0d", i));
        end

        drive(1, 0, 0, 0, 0, 10, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

Parametrised prescaled event counter: a programmable clock divider produces a one-cycle `tick` every `DIV` enabled clock cycles, and a `CNT_W`-bit counter advances on each tick. It supersedes the fixed 1 s / 5-bit counter in the hatch timing path. New behaviour: up/down counting, a runtime limit, wrap or saturate at the terminal value, synchronous load and clear, and a terminal-count pulse plus sticky flag for the hatch FSM.

## Interface
- `DIV`, 1000, prescaler period in `clk` cycles; legal range ≥ 2. Prescaler width is $clog2(DIV).
- `CNT_W`, 5, counter width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `st`  in  1  run enable; 1 = prescaler runs, 0 = prescaler and counter freeze.
- `clr`  in  1  synchronous clear of prescaler, counter and flags.
- `load`  in  1  synchronous load of `load_val` into the counter.
- `load_val`  in  CNT_W  load value; clamped to `limit`.
- `limit`  in  CNT_W  terminal value for up-count and reload value for down-wrap.
- `dir`  in  1  0 = count up, 1 = count down.
- `wrap_en`  in  1  1 = wrap at terminal, 0 = saturate (hold) at terminal.
- `cnt_num`  out  CNT_W  current count.
- `tick`  out  1  one-cycle pulse per prescaler period.
- `done`  out  1  one-cycle pulse when the count reaches its terminal value.
- `expired`  out  1  sticky terminal flag.

## Operation
- Priority on each edge: `rst`==0, then `clr`, then `load`, then prescaler/count activity.
- Reset (`rst`==0): prescaler `q`=0, `cnt_num`=0, `tick`=0, `done`=0, `expired`=0.
- `clr`=1 produces the same state as reset and overrides `st`.
- Prescaler when `st`=1: `q` increments by 1. At the edge where `q`==DIV-1, `q` goes to 0 and `tick` is registered to 1; otherwise `tick` is 0. The period is exactly `DIV` cycles, with no extra cycle.
- Prescaler when `st`=0: `q` holds, `tick`=0, and `cnt_num` holds. Stopping and restarting resumes from the held `q`.
- Count step: occurs on the same edge that sets `tick`.
  - Up mode, `cnt_num` < `limit`: `cnt_num`+1.
  - Up mode, `cnt_num` ≥ `limit`: the count is terminal. With `wrap_en` it goes to 0; otherwise it holds.
  - Down mode, `cnt_num` > 0: `cnt_num`-1.
  - Down mode, `cnt_num`==0: the count is terminal. With `wrap_en` it goes to `limit`; otherwise it holds at 0.
  - A count at or above the limit (for example after `limit` is lowered) is treated as terminal in up mode.
- `done` is set to 1 for one cycle on the edge where the counter becomes the terminal value: `limit` when counting up, 0 when counting down. A held saturated count does not re-pulse `done`.
- `expired` is set with `done` and cleared only by reset, `clr` or `load`.
- `load`=1:
  - `cnt_num` takes min(`load_val`, `limit`).
  - `done` is forced to 0.
  - The prescaler is unaffected: it continues if `st`=1, and `tick` may still pulse on that edge.
  - A coincident count step is discarded.
- `dir`, `wrap_en` and `limit` are sampled at each tick. Changes apply from the next tick.
- All arithmetic is modulo 2^CNT_W. No intermediate value wider than CNT_W bits is stored.

## Timing
- With `st` rising while `q`=0, the first `tick` and count change occur at edge DIV. Subsequent ones occur every DIV edges.
- `cnt_num`, `tick` and `done` are all registered and change on the same edge. There is no combinational path from inputs to outputs.
- `clr` and `load` take effect one edge after being sampled high.
- A reset asserted mid-period discards the partial prescaler count.

## Test plan
- Reset and basic count: DIV=4, CNT_W=5, limit=10, dir=0, wrap_en=1, st=1 after reset. Require `tick` at edges 4, 8, 12 and `cnt_num` 1, 2, 3 at those edges. Require all outputs 0 during reset.
- Up wrap vs saturate: limit=3, wrap_en=1. Require counts 1, 2, 3, 0, 1, with `done` pulsing once at the 3rd tick. Repeat with wrap_en=0: the count holds at 3, `done` pulses only once, and `expired` stays 1.
- Down mode: load_val=2, dir=1, wrap_en=1, limit=5. Require counts 1, 0 (`done` pulse), then 5, 4.
- Pause: drop `st` at `q`=2 for 7 cycles. Require no `tick` and a held count; after restart, the next `tick` comes 2 cycles later.
- Priority and clamp: assert `load` with load_val=20, limit=10 on a tick edge. Require `cnt_num`=10, `tick`=1, `done`=0, and `expired` cleared. Then `clr` and `load` together: require all zero.
- Reset mid-operation: at cnt_num=7 and `q`=3, pull `rst` low for one edge. Require everything zero, and the first `tick` DIV edges after `rst` is released.
